ex_muldiv_unit: RTL and testbench

HI/LO multiply-divide unit in the EX stage. It consumes the operation code and the two register operands that the ID/EX pipeline register delivers to EX, and owns the architectural HI and LO registers. Multiplies are a fixed 2-cycle pipeline; divides are a 1-bit-per-cycle iterative divider. It raises a stall request to the hazard unit whenever EX presents a HI/LO-dependent instruction while a previous operation is still in flight.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_divider.sv | 63 ++++++
 rtl/ex_muldiv_unit.sv | 124 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply-divide unit:
// operation encodings, FSM states and small decode helpers.
package muldiv_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MFHI  = 4'd1;
    localparam logic [3:0] MD_MFLO  = 4'd2;
    localparam logic [3:0] MD_MTHI  = 4'd3;
    localparam logic [3:0] MD_MTLO  = 4'd4;
    localparam logic [3:0] MD_MULT  = 4'd5;
    localparam logic [3:0] MD_MULTU = 4'd6;
    localparam logic [3:0] MD_DIV   = 4'd7;
    localparam logic [3:0] MD_DIVU  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL1,
        ST_DIV,
        ST_FIX
    } mdState_t;

    function automatic logic isMulOp(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider, one quotient bit per cycle; operates on
// magnitudes and applies the recorded signs on its outputs.
module muldiv_divider
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        isSigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] quoReg, remReg, divReg;
    logic [4:0]  countReg;
    logic        runReg, qSignReg, rSignReg;
    logic [31:0] absDividend, absDivisor;
    logic [32:0] shifted, diff;
    logic        fits;

    assign absDividend = (isSigned && dividend[31]) ? -dividend : dividend;
    assign absDivisor  = (isSigned && divisor[31])  ? -divisor  : divisor;

    // The partial remainder stays below the divisor, so 33 bits hold the trial.
    assign shifted = {remReg, quoReg[31]};
    assign diff    = shifted - {1'b0, divReg};
    assign fits    = !diff[32];

    always_ff @(posedge clock) begin
        if (!reset) begin
            quoReg   <= '0;
            remReg   <= '0;
            divReg   <= '0;
            countReg <= '0;
            runReg   <= 1'b0;
            qSignReg <= 1'b0;
            rSignReg <= 1'b0;
        end else if (start) begin
            quoReg   <= absDividend;
            remReg   <= '0;
            divReg   <= absDivisor;
            countReg <= 5'(DIV_ITERS - 1);
            runReg   <= 1'b1;
            qSignReg <= isSigned && (dividend[31] ^ divisor[31]);
            rSignReg <= isSigned && dividend[31];
        end else if (runReg) begin
            remReg   <= fits ? diff[31:0] : shifted[31:0];
            quoReg   <= {quoReg[30:0], fits};
            countReg <= countReg - 5'd1;
            if (countReg == 5'd0) begin
                runReg <= 1'b0;
            end
        end
    end

    assign done      = runReg && (countReg == 5'd0);
    assign quotient  = qSignReg ? -quoReg : quoReg;
    assign remainder = rSignReg ? -remReg : remReg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: owns HI/LO, runs the 2-cycle multiply path and
// sequences the iterative divider, stalling HI/LO users while busy.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  EX_MDOp,
    input  logic [31:0] EX_Rs,
    input  logic [31:0] EX_Rt,
    input  logic        EX_Hold,
    output logic [31:0] EX_MDResult,
    output logic        EX_MDStall,
    output logic        MD_Busy
);

    mdState_t           stateReg, stateNext;
    logic [31:0]        hiReg, loReg, hiNext, loNext;
    logic signed [32:0] mulAReg, mulBReg;
    logic [3:0]         mulOpReg;
    logic               divZeroReg;
    logic [31:0]        zeroRemReg;
    logic               opValid, accept, opIsMul, opIsDiv, opSigned, divStart, divDone;
    logic [31:0]        divQuot, divRem;
    logic [63:0]        product, accSum, accDiff;

    assign opValid  = (EX_MDOp != MD_NONE) && (EX_MDOp <= MD_MSUBU);
    assign MD_Busy  = (stateReg != ST_IDLE);
    assign accept   = opValid && !MD_Busy && !EX_Hold;
    // Stall must not look at EX_Hold, otherwise hazard logic forms a loop.
    assign EX_MDStall = opValid && MD_Busy;
    assign opIsMul  = isMulOp(EX_MDOp);
    assign opIsDiv  = (EX_MDOp == MD_DIV) || (EX_MDOp == MD_DIVU);
    assign opSigned = isSignedOp(EX_MDOp);
    assign divStart = accept && opIsDiv && (EX_Rt != 32'd0);

    assign EX_MDResult = (EX_MDOp == MD_MFHI) ? hiReg :
                         (EX_MDOp == MD_MFLO) ? loReg : 32'd0;

    assign product = $signed({{31{mulAReg[32]}}, mulAReg}) * $signed({{31{mulBReg[32]}}, mulBReg});
    assign accSum  = {hiReg, loReg} + product;
    assign accDiff = {hiReg, loReg} - product;

    muldiv_divider uDivider (
        .clock     (clock),
        .reset     (reset),
        .start     (divStart),
        .isSigned  (opSigned),
        .dividend  (EX_Rs),
        .divisor   (EX_Rt),
        .quotient  (divQuot),
        .remainder (divRem),
        .done      (divDone)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg   <= ST_IDLE;
            hiReg      <= '0;
            loReg      <= '0;
            mulAReg    <= '0;
            mulBReg    <= '0;
            mulOpReg   <= MD_NONE;
            divZeroReg <= 1'b0;
            zeroRemReg <= '0;
        end else begin
            stateReg <= stateNext;
            hiReg    <= hiNext;
            loReg    <= loNext;
            if (accept && opIsMul) begin
                mulAReg  <= {opSigned & EX_Rs[31], EX_Rs};
                mulBReg  <= {opSigned & EX_Rt[31], EX_Rt};
                mulOpReg <= EX_MDOp;
            end
            if (accept && opIsDiv) begin
                divZeroReg <= (EX_Rt == 32'd0);
                zeroRemReg <= EX_Rs;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        hiNext    = hiReg;
        loNext    = loReg;
        case (stateReg)
            ST_IDLE: begin
                if (accept) begin
                    if (EX_MDOp == MD_MTHI) hiNext = EX_Rs;
                    if (EX_MDOp == MD_MTLO) loNext = EX_Rs;
                    if (opIsMul) stateNext = ST_MUL1;
                    if (opIsDiv) stateNext = (EX_Rt == 32'd0) ? ST_FIX : ST_DIV;
                end
            end
            ST_MUL1: begin
                if (mulOpReg == MD_MADD || mulOpReg == MD_MADDU) begin
                    {hiNext, loNext} = accSum;
                end else if (mulOpReg == MD_MSUB || mulOpReg == MD_MSUBU) begin
                    {hiNext, loNext} = accDiff;
                end else begin
                    {hiNext, loNext} = product;
                end
                stateNext = ST_IDLE;
            end
            ST_DIV: begin
                if (divDone) stateNext = ST_FIX;
            end
            ST_FIX: begin
                if (divZeroReg) begin
                    loNext = DIV_ZERO_Q;
                    hiNext = zeroRemReg;
                end else begin
                    loNext = divQuot;
                    hiNext = divRem;
                end
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: HI/LO moves, multiply/accumulate,
// signed/unsigned divide, divide-by-zero, stall/hold handshake and reset abort.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock;
    logic        reset;
    logic [3:0]  EX_MDOp;
    logic [31:0] EX_Rs;
    logic [31:0] EX_Rt;
    logic        EX_Hold;
    logic [31:0] EX_MDResult;
    logic        EX_MDStall;
    logic        MD_Busy;

    int checkCount = 0;
    int errorCount = 0;

    ex_muldiv_unit #(.DIV_ZERO_Q(32'hFFFFFFFF)) dut (
        .clock       (clock),
        .reset       (reset),
        .EX_MDOp     (EX_MDOp),
        .EX_Rs       (EX_Rs),
        .EX_Rt       (EX_Rt),
        .EX_Hold     (EX_Hold),
        .EX_MDResult (EX_MDResult),
        .EX_MDStall  (EX_MDStall),
        .MD_Busy     (MD_Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Present one op for a single accept edge, then count the busy cycles.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int expBusy);
        int busy;
        EX_MDOp = op;
        EX_Rs   = rs;
        EX_Rt   = rt;
        cycle();
        EX_MDOp = MD_NONE;
        busy = 0;
        while (MD_Busy && busy < 200) begin
            busy++;
            cycle();
        end
        checkVal({tag, "_busy"}, 32'(busy), 32'(expBusy));
    endtask

    task automatic readHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        EX_MDOp = MD_MFHI;
        #1;
        checkVal({tag, "_hi"}, EX_MDResult, expHi);
        EX_MDOp = MD_MFLO;
        #1;
        checkVal({tag, "_lo"}, EX_MDResult, expLo);
        EX_MDOp = MD_NONE;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset   = 1'b0;
        EX_MDOp = MD_NONE;
        EX_Rs   = '0;
        EX_Rt   = '0;
        EX_Hold = 1'b0;
        repeat (3) cycle();
        checkVal("rst_busy", 32'(MD_Busy), 32'd0);
        checkVal("rst_stall", 32'(EX_MDStall), 32'd0);
        checkVal("rst_result", EX_MDResult, 32'd0);
        reset = 1'b1;
        cycle();
        readHiLo("rst", 32'd0, 32'd0);

        // Signed vs unsigned multiply of the same bit patterns
        runOp("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 1);
        readHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1);
        readHiLo("multu", 32'h00000001, 32'hFFFFFFFE);

        // MFHI presented right behind a multiply stalls one cycle, then sees the product
        EX_MDOp = MD_MULTU; EX_Rs = 32'h00010000; EX_Rt = 32'h00030000;
        cycle();
        EX_MDOp = MD_MFHI;
        #1;
        checkVal("mul_b2b_stall", 32'(EX_MDStall), 32'd1);
        cycle();
        checkVal("mul_b2b_nostall", 32'(EX_MDStall), 32'd0);
        checkVal("mul_b2b_hi", EX_MDResult, 32'h00000003);
        EX_MDOp = MD_NONE;
        cycle();

        // Moves then multiply-accumulate / subtract
        runOp("mthi", MD_MTHI, 32'd0, 32'd0, 0);
        runOp("mtlo", MD_MTLO, 32'd10, 32'd0, 0);
        readHiLo("mt", 32'd0, 32'd10);
        runOp("madd", MD_MADD, 32'd3, 32'd4, 1);
        readHiLo("madd", 32'd0, 32'd22);
        runOp("msub", MD_MSUB, 32'd5, 32'd5, 1);
        readHiLo("msub", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // Divides
        runOp("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 33);
        readHiLo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div_negrt", MD_DIV, 32'd7, 32'hFFFFFFFE, 33);
        readHiLo("div_negrt", 32'd1, 32'hFFFFFFFD);
        runOp("divu", MD_DIVU, 32'd100, 32'd7, 33);
        readHiLo("divu", 32'd2, 32'd14);
        runOp("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h00010000, 33);
        readHiLo("divu_big", 32'h0000FFFF, 32'h0000FFFF);
        runOp("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 33);
        readHiLo("div_ovf", 32'd0, 32'h80000000);
        runOp("divz", MD_DIVU, 32'h00001234, 32'd0, 1);
        readHiLo("divz", 32'h00001234, 32'hFFFFFFFF);

        // MFHI issued one cycle after a divide accept waits out the divide
        EX_MDOp = MD_DIV; EX_Rs = 32'd100; EX_Rt = 32'd7;
        cycle();
        EX_MDOp = MD_NONE;
        cycle();
        EX_MDOp = MD_MFHI;
        #1;
        n = 0;
        while (EX_MDStall && n < 200) begin
            n++;
            cycle();
        end
        checkVal("mfhi_stall_cycles", 32'(n), 32'd32);
        checkVal("mfhi_release", EX_MDResult, 32'd2);
        EX_MDOp = MD_NONE;
        cycle();

        // EX_Hold on the release cycle delays acceptance by exactly one edge
        EX_MDOp = MD_DIVU; EX_Rs = 32'd100; EX_Rt = 32'd7;
        cycle();
        EX_MDOp = MD_MADDU; EX_Rs = 32'd3; EX_Rt = 32'd4;
        #1;
        n = 0;
        while (EX_MDStall && n < 200) begin
            n++;
            cycle();
        end
        checkVal("hold_stall_cycles", 32'(n), 32'd33);
        EX_Hold = 1'b1;
        #1;
        checkVal("hold_stall_low", 32'(EX_MDStall), 32'd0);
        cycle();
        checkVal("hold_not_accepted", 32'(MD_Busy), 32'd0);
        EX_Hold = 1'b0;
        cycle();
        checkVal("hold_accepted", 32'(MD_Busy), 32'd1);
        EX_MDOp = MD_NONE;
        cycle();
        checkVal("hold_done", 32'(MD_Busy), 32'd0);
        readHiLo("hold_maddu", 32'd2, 32'd26);

        // Reset in the middle of a divide
        EX_MDOp = MD_DIV; EX_Rs = 32'd100; EX_Rt = 32'd7;
        cycle();
        EX_MDOp = MD_NONE;
        repeat (9) cycle();
        checkVal("mid_div_busy", 32'(MD_Busy), 32'd1);
        reset = 1'b0;
        cycle();
        checkVal("rst_mid_busy", 32'(MD_Busy), 32'd0);
        reset = 1'b1;
        cycle();
        readHiLo("rst_mid", 32'd0, 32'd0);
        cycle();
        checkVal("rst_mid_idle", 32'(MD_Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
